// File: rtl/saber_mul_pkg.sv
// Shared constants and FSM state for the Saber matrix-vector scheduler.
// Word counts are in 64-bit memory words.
package saber_mul_pkg;

    localparam int POLY_WORDS13 = 52;
    localparam int POLY_WORDS16 = 64;
    localparam int SEC_WORDS    = 16;
    localparam int RES_WORDS    = 64;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        MRST,
        MRUN,
        READ,
        DONE
    } sched_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/saber_matvec_scheduler_if.sv
// Shared memory port plus multiplier control/status bundle.
// master = scheduler side, slave = memory/multiplier side.
interface saber_matvec_scheduler_if #(
    parameter int ADDR_W = 12
);

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [63:0]       mem_wdata;
    logic              mul_rst;
    logic              mul_acc_clear;
    logic              mul_read;
    logic              mul_coeff4x;
    logic              mul_done;
    logic [6:0]        mul_bram_addr_rel;
    logic [7:0]        mul_s_addr;
    logic              mul_s_load_now;
    logic [63:0]       mul_coeff4x_out;

    modport master (
        output mem_addr, mem_we, mem_wdata,
        output mul_rst, mul_acc_clear, mul_read,
        output mul_coeff4x,
        input  mul_done, mul_bram_addr_rel,
        input  mul_s_addr, mul_s_load_now,
        input  mul_coeff4x_out
    );

    modport slave (
        input  mem_addr, mem_we, mem_wdata,
        input  mul_rst, mul_acc_clear, mul_read,
        input  mul_coeff4x,
        output mul_done, mul_bram_addr_rel,
        output mul_s_addr, mul_s_load_now,
        output mul_coeff4x_out
    );

endinterface

// File: rtl/matvec_index_gen.sv
// Row/product/readout counters and the A, s and result offsets,
// built with running adders so no address multiplier is needed.
module matvec_index_gen
    import saber_mul_pkg::*;
#(
    parameter int L            = 3,
    parameter int ADDR_W       = 12,
    parameter int POLY_WORDS13 = saber_mul_pkg::POLY_WORDS13,
    parameter int POLY_WORDS16 = saber_mul_pkg::POLY_WORDS16,
    parameter int SEC_WORDS    = saber_mul_pkg::SEC_WORDS,
    parameter int RES_WORDS    = saber_mul_pkg::RES_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              transpose,
    input  logic              coeff4x,
    input  logic              op_start,
    input  logic              row_start,
    input  logic              j_adv,
    input  logic              k_adv,
    input  logic              i_adv,
    output logic              i_last,
    output logic              j_last,
    output logic              k_last,
    output logic [ADDR_W-1:0] a_off,
    output logic [ADDR_W-1:0] s_off,
    output logic [ADDR_W-1:0] r_off
);

    localparam int IW = cnt_w(L);
    localparam int KW = cnt_w(RES_WORDS);

    logic [IW-1:0]     i_q;
    logic [IW-1:0]     j_q;
    logic [KW-1:0]     k_q;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] col_acc;
    logic [ADDR_W-1:0] s_acc;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] pw;
    logic [ADDR_W-1:0] lpw;
    logic [ADDR_W-1:0] row_step;
    logic [ADDR_W-1:0] col_step;

    // One polynomial stride and one full matrix row stride; the
    // transposed walk simply swaps which counter uses which.
    assign pw  = coeff4x ? ADDR_W'(POLY_WORDS16) : ADDR_W'(POLY_WORDS13);
    assign lpw = coeff4x ? ADDR_W'(L * POLY_WORDS16)
                         : ADDR_W'(L * POLY_WORDS13);
    assign row_step = transpose ? pw : lpw;
    assign col_step = transpose ? lpw : pw;

    assign i_last = (i_q == IW'(L - 1));
    assign j_last = (j_q == IW'(L - 1));
    assign k_last = (k_q == KW'(RES_WORDS - 1));
    assign a_off  = row_base + col_acc;
    assign s_off  = s_acc;
    assign r_off  = r_base + ADDR_W'(k_q);

    // Row counter and the per-row A / result bases.
    always_ff @(posedge clk) begin
        if (rst || op_start) begin
            i_q      <= '0;
            row_base <= '0;
            r_base   <= '0;
        end else if (i_adv) begin
            i_q      <= i_q + IW'(1);
            row_base <= row_base + row_step;
            r_base   <= r_base + ADDR_W'(RES_WORDS);
        end
    end

    // Product counter with its A column and secret offsets.
    always_ff @(posedge clk) begin
        if (rst || row_start) begin
            j_q     <= '0;
            col_acc <= '0;
            s_acc   <= '0;
        end else if (j_adv) begin
            j_q     <= j_q + IW'(1);
            col_acc <= col_acc + col_step;
            s_acc   <= s_acc + ADDR_W'(SEC_WORDS);
        end
    end

    // Readout word counter, restarted for every row.
    always_ff @(posedge clk) begin
        if (rst || row_start) begin
            k_q <= '0;
        end else if (k_adv) begin
            k_q <= k_q + KW'(1);
        end
    end

endmodule

// File: rtl/saber_matvec_scheduler.sv
// Drives the polynomial multiplier through an L x L matrix-vector
// product and owns the single shared data-memory port.
module saber_matvec_scheduler
    import saber_mul_pkg::*;
#(
    parameter int L            = 3,
    parameter int ADDR_W       = 12,
    parameter int POLY_WORDS13 = saber_mul_pkg::POLY_WORDS13,
    parameter int POLY_WORDS16 = saber_mul_pkg::POLY_WORDS16,
    parameter int SEC_WORDS    = saber_mul_pkg::SEC_WORDS,
    parameter int RES_WORDS    = saber_mul_pkg::RES_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              transpose,
    input  logic              coeff4x,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] s_base,
    input  logic [ADDR_W-1:0] res_base,
    output logic              busy,
    output logic              done,
    saber_matvec_scheduler_if.master bus
);

    sched_state_t      state;
    sched_state_t      nxt;
    logic              tr_q;
    logic              c4_q;
    logic [ADDR_W-1:0] a_q;
    logic [ADDR_W-1:0] s_q;
    logic [ADDR_W-1:0] r_q;
    logic              op_start;
    logic              row_start;
    logic              j_adv;
    logic              k_adv;
    logic              i_adv;
    logic              i_last;
    logic              j_last;
    logic              k_last;
    logic [ADDR_W-1:0] a_off;
    logic [ADDR_W-1:0] s_off;
    logic [ADDR_W-1:0] r_off;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [63:0]       wdata;
    logic              mrst;
    logic              aclr;
    logic              mread;

    matvec_index_gen #(
        .L            (L),
        .ADDR_W       (ADDR_W),
        .POLY_WORDS13 (POLY_WORDS13),
        .POLY_WORDS16 (POLY_WORDS16),
        .SEC_WORDS    (SEC_WORDS),
        .RES_WORDS    (RES_WORDS)
    ) u_idx (
        .clk       (clk),
        .rst       (rst),
        .transpose (tr_q),
        .coeff4x   (c4_q),
        .op_start  (op_start),
        .row_start (row_start),
        .j_adv     (j_adv),
        .k_adv     (k_adv),
        .i_adv     (i_adv),
        .i_last    (i_last),
        .j_last    (j_last),
        .k_last    (k_last),
        .a_off     (a_off),
        .s_off     (s_off),
        .r_off     (r_off)
    );

    assign bus.mem_addr      = addr;
    assign bus.mem_we        = we;
    assign bus.mem_wdata     = wdata;
    assign bus.mul_rst       = mrst;
    assign bus.mul_acc_clear = aclr;
    assign bus.mul_read      = mread;
    assign bus.mul_coeff4x   = c4_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Operation parameters, captured only when a start is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            tr_q <= 1'b0;
            c4_q <= 1'b0;
            a_q  <= '0;
            s_q  <= '0;
            r_q  <= '0;
        end else if (op_start) begin
            tr_q <= transpose;
            c4_q <= coeff4x;
            a_q  <= a_base;
            s_q  <= s_base;
            r_q  <= res_base;
        end
    end

    // Next state, memory mux and multiplier strobes. Reset forces the
    // idle outputs at once so no write leaks through the reset cycle.
    always_comb begin
        nxt       = state;
        busy      = 1'b0;
        done      = 1'b0;
        addr      = '0;
        we        = 1'b0;
        wdata     = '0;
        mrst      = 1'b0;
        aclr      = 1'b0;
        mread     = 1'b0;
        op_start  = 1'b0;
        row_start = 1'b0;
        j_adv     = 1'b0;
        k_adv     = 1'b0;
        i_adv     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    op_start = 1'b1;
                    nxt      = CLR;
                end
            end
            CLR: begin
                busy      = 1'b1;
                aclr      = 1'b1;
                row_start = 1'b1;
                nxt       = MRST;
            end
            MRST: begin
                busy = 1'b1;
                mrst = 1'b1;
                nxt  = MRUN;
            end
            MRUN: begin
                busy = 1'b1;
                if (bus.mul_s_load_now) begin
                    addr = s_q + s_off + ADDR_W'(bus.mul_s_addr);
                end else begin
                    addr = a_q + a_off + ADDR_W'(bus.mul_bram_addr_rel);
                end
                if (bus.mul_done) begin
                    if (j_last) begin
                        nxt = READ;
                    end else begin
                        j_adv = 1'b1;
                        nxt   = MRST;
                    end
                end
            end
            READ: begin
                busy  = 1'b1;
                we    = 1'b1;
                addr  = r_q + r_off;
                wdata = bus.mul_coeff4x_out;
                mread = 1'b1;
                k_adv = 1'b1;
                if (k_last) begin
                    if (i_last) begin
                        nxt = DONE;
                    end else begin
                        i_adv = 1'b1;
                        nxt   = CLR;
                    end
                end
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
                nxt  = IDLE;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
        if (rst) begin
            nxt       = IDLE;
            busy      = 1'b0;
            done      = 1'b0;
            addr      = '0;
            we        = 1'b0;
            wdata     = '0;
            mrst      = 1'b1;
            aclr      = 1'b0;
            mread     = 1'b0;
            op_start  = 1'b0;
            row_start = 1'b0;
            j_adv     = 1'b0;
            k_adv     = 1'b0;
            i_adv     = 1'b0;
        end
    end

endmodule
